// File: rtl/traffic_checker.sv
// Receive-side sequence checker for the NoC traffic generator's 8-bit XNOR LFSR stream.
// Locks onto the stream, then counts accepted flits and in-lock sequence errors.
module traffic_checker #(
    parameter int CNT_WIDTH  = 16,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [7:0]           expected,
    output logic [CNT_WIDTH-1:0] rx_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [7:0] LOCKUP   = 8'hFF;
    localparam logic [7:0] LOCK_TGT = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_TGT = 8'(LOSS_COUNT);

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], ~(x[7] ^ x[3] ^ x[2] ^ x[1])};
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    logic [1:0] state, state_n;
    logic [7:0] expected_n;
    logic [7:0] match_cnt, match_n;
    logic [7:0] miss_cnt, miss_n;
    logic       err_hit;
    logic       accept;

    assign in_ready = enable & ~reset;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_n    = state;
        expected_n = expected;
        match_n    = match_cnt;
        miss_n     = miss_cnt;
        err_hit    = 1'b0;
        if (accept) begin
            case (state)
                HUNT: begin
                    if (in_data != LOCKUP) begin
                        expected_n = lfsr_next(in_data);
                        match_n    = 8'd0;
                        state_n    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (in_data == expected) begin
                        expected_n = lfsr_next(in_data);
                        match_n    = match_cnt + 8'd1;
                        if (match_cnt + 8'd1 == LOCK_TGT) begin
                            state_n = LOCKED;
                            miss_n  = 8'd0;
                        end
                    end else if (in_data != LOCKUP) begin
                        expected_n = lfsr_next(in_data);
                        match_n    = 8'd0;
                    end else begin
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    // A bad flit is treated as corrupted, not lost: keep stepping the prediction.
                    expected_n = lfsr_next(expected);
                    if (in_data == expected) begin
                        miss_n = 8'd0;
                    end else begin
                        err_hit = 1'b1;
                        miss_n  = miss_cnt + 8'd1;
                        if (miss_cnt + 8'd1 == LOSS_TGT) begin
                            state_n = HUNT;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            expected  <= 8'h00;
            match_cnt <= 8'd0;
            miss_cnt  <= 8'd0;
            rx_count  <= '0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            locked    <= (state_n == LOCKED);
            err_pulse <= err_hit;
            expected  <= expected_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            // Clear wins over a same-cycle increment; the FSM still consumes that flit.
            if (clear) begin
                rx_count  <= '0;
                err_count <= '0;
            end else begin
                if (accept) begin
                    rx_count <= sat_inc(rx_count);
                end
                if (err_hit) begin
                    err_count <= sat_inc(err_count);
                end
            end
        end
    end

endmodule
